// File: rtl/mixcolumns_ctrl.sv
// Streams a 128-bit AES state through a shared 32-bit multi-cycle mixcolumns
// datapath one column per pass, with final-round bypass and abort-with-drain.
//
// state | meaning
// IDLE  | ready for a new state; abort ignored
// RUN   | presenting column col to the datapath until mc_done
// OUT   | result held on out_state until out_ready or abort
// DRAIN | aborted mid-pass; keep enable high until mc_done, then discard
module mixcolumns_ctrl (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    input  logic         abort,
    output logic         busy,
    output logic         mc_enable,
    output logic [31:0]  mc_istate,
    input  logic [31:0]  mc_ostate,
    input  logic         mc_done
);

    typedef enum logic [1:0] {IDLE, RUN, OUT, DRAIN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;
    logic [127:0] out_q, out_d;
    logic [127:0] res_upd;
    logic [31:0]  col_packed;

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        case (c)
            2'd0:    get_col = s[127:96];
            2'd1:    get_col = s[95:64];
            2'd2:    get_col = s[63:32];
            default: get_col = s[31:0];
        endcase
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] w);
        put_col = s;
        case (c)
            2'd0:    put_col[127:96] = w;
            2'd1:    put_col[95:64]  = w;
            2'd2:    put_col[63:32]  = w;
            default: put_col[31:0]   = w;
        endcase
    endfunction

    // The datapath wants the first byte of the column in its LSB.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        swap_bytes = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign col_packed = swap_bytes(get_col(src_q, col_q));
    assign res_upd    = put_col(res_q, col_q, swap_bytes(mc_ostate));
    assign out_state  = out_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        src_d     = src_q;
        res_d     = res_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mc_enable = 1'b0;
        mc_istate = 32'h0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) begin
                    src_d = in_state;
                    col_d = 2'd0;
                    if (in_bypass) begin
                        out_d   = in_state;
                        state_d = OUT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                mc_enable = 1'b1;
                mc_istate = col_packed;
                if (mc_done) begin
                    if (abort) begin
                        state_d = IDLE;
                    end else begin
                        res_d = res_upd;
                        if (col_q == 2'd3) begin
                            out_d   = res_upd;
                            state_d = OUT;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                end else if (abort) begin
                    state_d = DRAIN;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready || abort) state_d = IDLE;
            end
            DRAIN: begin
                // Datapath counter only clears by finishing its pass.
                mc_enable = 1'b1;
                mc_istate = col_packed;
                if (mc_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            src_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            src_q   <= src_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end

endmodule
